// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Captures ALU results with a valid/ready handshake. It maintains the
//   CPSR and a sticky overflow bit. Register-writing results go to the
//   register-file write port through an output register backed by a
//   one-entry skid register. in_ready is a flop, so the issue side never
//   sees a combinational path from wb_ready.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  issue-side handshake (in_ready registered)
//   in_opcode          opcode that produced in_r
//   in_option_bits     ALU option bits (3'b010 = FP compare)
//   in_set_flags       instruction requests a CPSR update
//   in_rd, in_r        destination index and ALU result
//   in_negative..in_nan  ALU integer and FP flags
//   wb_valid/wb_ready  register-file write handshake
//   wb_rd, wb_data     writeback index and data
//   cpsr               {N,Z,C,V,INF,SUB,NAN}
//   sticky_v           sticky overflow; clr_sticky clears it (a set wins)
//   illegal_op         one-cycle pulse after an undefined opcode is accepted
module alu_writeback_stage #(
   parameter int WIDTH    = 16,
   parameter int RD_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4:0]          in_opcode,
   input  logic [2:0]          in_option_bits,
   input  logic                in_set_flags,
   input  logic [RD_WIDTH-1:0] in_rd,
   input  logic [WIDTH-1:0]    in_r,
   input  logic                in_negative,
   input  logic                in_zero,
   input  logic                in_cout,
   input  logic                in_overflow,
   input  logic                in_inf,
   input  logic                in_subnormal,
   input  logic                in_nan,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [RD_WIDTH-1:0] wb_rd,
   output logic [WIDTH-1:0]    wb_data,
   output logic [6:0]          cpsr,
   output logic                sticky_v,
   input  logic                clr_sticky,
   output logic                illegal_op
);

   localparam logic [4:0] OP_CMP    = 5'b00101;
   localparam logic [2:0] OPT_FPCMP = 3'b010;

   // Opcode decode
   logic is_cmp, is_fp, is_ill, is_wb;

   always_comb begin
      is_cmp = (in_opcode == OP_CMP);
      is_ill = 1'b0;
      is_fp  = 1'b0;
      case (in_opcode)
         5'b01101, 5'b01110,
         5'b10100, 5'b10101, 5'b10110, 5'b10111,
         5'b11101, 5'b11110, 5'b11111: is_ill = 1'b1;
         5'b10001, 5'b10010, 5'b10011: is_fp  = 1'b1;
         default: ;
      endcase
      // A compare counts as FP only when the option bits select an FP compare.
      if (is_cmp && (in_option_bits == OPT_FPCMP)) begin
         is_fp = 1'b1;
      end
      is_wb = !is_cmp && !is_ill;
   end

   // State
   logic [6:0]          cpsr_reg, cpsr_next;
   logic                sticky_reg, sticky_next;
   logic                illegal_reg, illegal_next;
   logic                ready_reg, ready_next;
   logic                out_valid_reg, out_valid_next;
   logic [RD_WIDTH-1:0] out_rd_reg, out_rd_next;
   logic [WIDTH-1:0]    out_data_reg, out_data_next;
   logic                skid_valid_reg, skid_valid_next;
   logic [RD_WIDTH-1:0] skid_rd_reg, skid_rd_next;
   logic [WIDTH-1:0]    skid_data_reg, skid_data_next;

   logic accept, push, flag_upd;

   always_comb begin
      accept   = in_valid && ready_reg;
      push     = accept && is_wb;
      flag_upd = accept && !is_ill && (in_set_flags || is_cmp);

      // Status flags
      cpsr_next    = cpsr_reg;
      sticky_next  = sticky_reg;
      illegal_next = accept && is_ill;
      if (flag_upd) begin
         cpsr_next[6:3] = {in_negative, in_zero, in_cout, in_overflow};
         if (is_fp) begin
            cpsr_next[2:0] = {in_inf, in_subnormal, in_nan};
         end
      end
      // The set term is tested first, so a set in the same cycle as a clear wins.
      if (flag_upd && in_overflow) begin
         sticky_next = 1'b1;
      end else if (clr_sticky) begin
         sticky_next = 1'b0;
      end

      // Writeback buffer
      out_valid_next  = out_valid_reg;
      out_rd_next     = out_rd_reg;
      out_data_next   = out_data_reg;
      skid_valid_next = skid_valid_reg;
      skid_rd_next    = skid_rd_reg;
      skid_data_next  = skid_data_reg;
      if (!out_valid_reg || wb_ready) begin
         // The output register is free, or is being drained this cycle.
         if (skid_valid_reg) begin
            // The skid entry is older, so it moves forward first.
            out_valid_next  = 1'b1;
            out_rd_next     = skid_rd_reg;
            out_data_next   = skid_data_reg;
            skid_valid_next = push;
            if (push) begin
               skid_rd_next   = in_rd;
               skid_data_next = in_r;
            end
         end else if (push) begin
            out_valid_next = 1'b1;
            out_rd_next    = in_rd;
            out_data_next  = in_r;
         end else begin
            out_valid_next = 1'b0;
         end
      end else if (push) begin
         // The output register is stalled, so park the beat in the skid register.
         skid_valid_next = 1'b1;
         skid_rd_next    = in_rd;
         skid_data_next  = in_r;
      end
      // in_ready for the next cycle depends only on next-state skid occupancy.
      ready_next = !skid_valid_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpsr_reg       <= '0;
         sticky_reg     <= 1'b0;
         illegal_reg    <= 1'b0;
         ready_reg      <= 1'b1;
         out_valid_reg  <= 1'b0;
         out_rd_reg     <= '0;
         out_data_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_rd_reg    <= '0;
         skid_data_reg  <= '0;
      end else begin
         cpsr_reg       <= cpsr_next;
         sticky_reg     <= sticky_next;
         illegal_reg    <= illegal_next;
         ready_reg      <= ready_next;
         out_valid_reg  <= out_valid_next;
         out_rd_reg     <= out_rd_next;
         out_data_reg   <= out_data_next;
         skid_valid_reg <= skid_valid_next;
         skid_rd_reg    <= skid_rd_next;
         skid_data_reg  <= skid_data_next;
      end
   end

   assign in_ready   = ready_reg;
   assign wb_valid   = out_valid_reg;
   assign wb_rd      = out_rd_reg;
   assign wb_data    = out_data_reg;
   assign cpsr       = cpsr_reg;
   assign sticky_v   = sticky_reg;
   assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage
//   Directed scenarios followed by a randomized run. Every cycle the DUT
//   is compared against a reference model: a depth-2 FIFO of pending
//   writebacks, plus CPSR, sticky and illegal bits computed from the
//   opcode-class rules.
module tb_alu_writeback_stage;

   localparam int WIDTH    = 16;
   localparam int RD_WIDTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [4:0]          in_opcode;
   logic [2:0]          in_option_bits;
   logic                in_set_flags;
   logic [RD_WIDTH-1:0] in_rd;
   logic [WIDTH-1:0]    in_r;
   logic                in_negative, in_zero, in_cout, in_overflow;
   logic                in_inf, in_subnormal, in_nan;
   logic                wb_valid;
   logic                wb_ready;
   logic [RD_WIDTH-1:0] wb_rd;
   logic [WIDTH-1:0]    wb_data;
   logic [6:0]          cpsr;
   logic                sticky_v;
   logic                clr_sticky;
   logic                illegal_op;

   alu_writeback_stage #(.WIDTH(WIDTH), .RD_WIDTH(RD_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_option_bits(in_option_bits),
      .in_set_flags(in_set_flags), .in_rd(in_rd), .in_r(in_r),
      .in_negative(in_negative), .in_zero(in_zero), .in_cout(in_cout),
      .in_overflow(in_overflow), .in_inf(in_inf), .in_subnormal(in_subnormal),
      .in_nan(in_nan),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .cpsr(cpsr), .sticky_v(sticky_v), .clr_sticky(clr_sticky),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [19:0] wq[$];           // {rd, data} of beats waiting to be written
   logic [6:0]  m_cpsr   = '0;
   logic        m_sticky = 1'b0;
   logic        m_ill    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit op_cmp(input logic [4:0] op);
      return op == 5'b00101;
   endfunction

   function automatic bit op_ill(input logic [4:0] op);
      return op inside {5'b01101, 5'b01110, [5'b10100:5'b10111], [5'b11101:5'b11111]};
   endfunction

   function automatic bit op_fp(input logic [4:0] op, input logic [2:0] opt);
      return (op inside {[5'b10001:5'b10011]}) || (op == 5'b00101 && opt == 3'b010);
   endfunction

   task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] opt,
                        input logic sf, input logic [3:0] rd, input logic [15:0] r,
                        input logic [6:0] fl);
      in_valid = v; in_opcode = op; in_option_bits = opt; in_set_flags = sf;
      in_rd = rd; in_r = r;
      {in_negative, in_zero, in_cout, in_overflow, in_inf, in_subnormal, in_nan} = fl;
   endtask

   // One clock: predict from the inputs held across the edge, then compare.
   task automatic tick();
      bit acc, drain, upd;
      acc   = in_valid && (wq.size() < 2);
      drain = (wq.size() > 0) && wb_ready;
      upd   = acc && !op_ill(in_opcode) && (in_set_flags || op_cmp(in_opcode));
      @(posedge clk);
      #1;
      if (rst) begin
         wq.delete();
         m_cpsr = '0; m_sticky = 1'b0; m_ill = 1'b0;
      end else begin
         if (drain) void'(wq.pop_front());
         if (acc && !op_cmp(in_opcode) && !op_ill(in_opcode)) wq.push_back({in_rd, in_r});
         m_ill = acc && op_ill(in_opcode);
         if (upd) begin
            m_cpsr[6:3] = {in_negative, in_zero, in_cout, in_overflow};
            if (op_fp(in_opcode, in_option_bits))
               m_cpsr[2:0] = {in_inf, in_subnormal, in_nan};
         end
         if (upd && in_overflow) m_sticky = 1'b1;
         else if (clr_sticky)    m_sticky = 1'b0;
      end
      chk("in_ready",   32'(in_ready),   32'(wq.size() < 2));
      chk("wb_valid",   32'(wb_valid),   32'(wq.size() > 0));
      if (wq.size() > 0) chk("wb_beat", {12'h0, wb_rd, wb_data}, {12'h0, wq[0]});
      chk("cpsr",       32'(cpsr),       32'(m_cpsr));
      chk("sticky_v",   32'(sticky_v),   32'(m_sticky));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
   endtask

   initial begin
      rst = 1'b1; wb_ready = 1'b1; clr_sticky = 1'b0;
      drive(1'b1, 5'b00001, 3'b000, 1'b1, 4'd1, 16'hdead, 7'b1111111);

      // Reset held for two cycles while in_valid=1
      tick(); tick();
      chk("rst_cpsr",  32'(cpsr),     32'd0);
      chk("rst_wbv",   32'(wb_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_stick", 32'(sticky_v), 32'd0);
      rst = 1'b0;

      // ADD with C=1, V=1
      drive(1'b1, 5'b00001, 3'b000, 1'b1, 4'd3, 16'h1234, 7'b0011000);
      tick();
      chk("add_wbv",   32'(wb_valid), 32'd1);
      chk("add_rd",    32'(wb_rd),    32'd3);
      chk("add_data",  32'(wb_data),  32'h1234);
      chk("add_cpsr",  32'(cpsr),     32'b0011000);
      chk("add_stick", 32'(sticky_v), 32'd1);

      // FP compare with Z=1, NAN=1 and set_flags=0
      drive(1'b1, 5'b00101, 3'b010, 1'b0, 4'd5, 16'h5555, 7'b0100001);
      tick();
      chk("cmp_wbv",   32'(wb_valid), 32'd0);
      chk("cmp_cpsr",  32'(cpsr),     32'b0100001);
      // Integer compare: INF/SUB/NAN must hold
      drive(1'b1, 5'b00101, 3'b001, 1'b0, 4'd5, 16'h5555, 7'b0010110);
      tick();
      chk("icmp_cpsr", 32'(cpsr),     32'b0010001);

      // Illegal opcode with V=1, after first clearing sticky_v
      drive(1'b0, 5'b00000, 3'b000, 1'b0, 4'd0, 16'h0, 7'b0);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      drive(1'b1, 5'b01101, 3'b000, 1'b1, 4'd7, 16'h7777, 7'b1111111);
      tick();
      chk("ill_pulse", 32'(illegal_op), 32'd1);
      chk("ill_cpsr",  32'(cpsr),       32'b0010001);
      chk("ill_stick", 32'(sticky_v),   32'd0);
      chk("ill_wbv",   32'(wb_valid),   32'd0);
      drive(1'b0, 5'b00000, 3'b000, 1'b0, 4'd0, 16'h0, 7'b0);
      tick();
      chk("ill_end",   32'(illegal_op), 32'd0);

      // Back-pressure: A, B, C issued while wb_ready=0
      wb_ready = 1'b0;
      drive(1'b1, 5'b00010, 3'b000, 1'b0, 4'd1, 16'haaaa, 7'b0); tick();
      drive(1'b1, 5'b00010, 3'b000, 1'b0, 4'd2, 16'hbbbb, 7'b0); tick();
      chk("bp_full",   32'(in_ready), 32'd0);
      drive(1'b1, 5'b00010, 3'b000, 1'b0, 4'd4, 16'hcccc, 7'b0); tick();
      chk("bp_hold",   32'(wb_data),  32'haaaa);
      chk("bp_block",  32'(in_ready), 32'd0);
      wb_ready = 1'b1;
      tick();
      chk("bp_b",      32'(wb_data),  32'hbbbb);
      chk("bp_rdy",    32'(in_ready), 32'd1);
      tick();
      chk("bp_c",      32'(wb_data),  32'hcccc);
      drive(1'b0, 5'b00000, 3'b000, 1'b0, 4'd0, 16'h0, 7'b0);
      tick();
      chk("bp_empty",  32'(wb_valid), 32'd0);

      // Sticky priority: a set in the same cycle as clr_sticky wins
      clr_sticky = 1'b1;
      drive(1'b1, 5'b00011, 3'b000, 1'b1, 4'd6, 16'h0606, 7'b0001000);
      tick();
      chk("stk_set",   32'(sticky_v), 32'd1);
      drive(1'b0, 5'b00000, 3'b000, 1'b0, 4'd0, 16'h0, 7'b0);
      tick();
      chk("stk_clr",   32'(sticky_v), 32'd0);
      clr_sticky = 1'b0;

      // Randomized run checked against the model
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         wb_ready   = ($urandom_range(0, 1) == 1);
         clr_sticky = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
               ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 7'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Sits directly downstream of the 16-bit combinational ALU. Captures each ALU result and its flags with a valid/ready handshake.
- Maintains the architectural status register (CPSR) and a sticky overflow bit.
- Forwards register-writing results to the register-file write port through a 2-entry skid buffer, so ALU issue never stalls on a combinational ready path.

Parameters:
- WIDTH, 16, data width of ALU result and writeback data.
- RD_WIDTH, 4, width of destination register index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  issue side holds a completed ALU operation.
- in_ready  output  1  stage can accept; registered, not combinational from wb_ready.
- in_opcode  input  5  opcode that produced in_r.
- in_option_bits  input  3  ALU option bits (3'b010 = FP compare).
- in_set_flags  input  1  instruction requests CPSR update.
- in_rd  input  RD_WIDTH  destination register index.
- in_r  input  WIDTH  ALU result.
- in_negative, in_zero, in_cout, in_overflow  input  1 each  ALU integer flags.
- in_inf, in_subnormal, in_nan  input  1 each  ALU FP flags.
- wb_valid  output  1  writeback beat present.
- wb_ready  input  1  register file accepts beat.
- wb_rd  output  RD_WIDTH  writeback register index.
- wb_data  output  WIDTH  writeback data.
- cpsr  output  7  {N,Z,C,V,INF,SUB,NAN}, bit6 = N down to bit0 = NAN.
- sticky_v  output  1  sticky overflow.
- clr_sticky  input  1  clear sticky_v.
- illegal_op  output  1  one-cycle pulse on acceptance of undefined opcode.

Behaviour:
- Reset (sync, rst=1 at edge): cpsr=0, sticky_v=0, wb_valid=0, wb_rd=0, wb_data=0, illegal_op=0, in_ready=1. Any buffered beats are discarded; reset mid-transfer drops them silently.
- Accept: a beat is accepted when in_valid && in_ready at the rising edge. in_ready = !skid_full, registered.
- Opcode classes:
  - Compare: 5'b00101. Never writes back; always updates CPSR regardless of in_set_flags.
  - FP: 10001, 10010, 10011, and compare with option_bits==3'b010. Update INF/SUB/NAN.
  - Illegal: 01101, 01110, 10100–10111, 11101–11111. Consumed with no writeback and no CPSR/sticky change; illegal_op=1 the next cycle only.
  - All other opcodes: writeback.
- CPSR update on accept, visible the cycle after:
  - If (in_set_flags || compare) && !illegal, N/Z/C/V take in_* values.
  - INF/SUB/NAN take in_* values only for FP class ops that update flags; otherwise they hold.
  - No update otherwise.
- sticky_v:
  - Set on any accepted flag-updating beat with in_overflow=1.
  - Cleared by clr_sticky.
  - Set and clear in the same cycle: set wins.
- Writeback buffer (output reg + skid reg):
  - Latency 1: a beat accepted at edge N appears on wb_* after edge N.
  - Output reg empty, or wb_ready=1: the accepted beat loads the output reg.
  - Output reg full and wb_ready=0: the beat loads the skid reg; in_ready drops to 0 the next cycle.
  - On wb_ready with skid full: skid moves to output reg; in_ready returns to 1 the next cycle.
  - Beat order is preserved.
  - wb_rd/wb_data hold stable while wb_valid && !wb_ready.
  - Non-writeback beats (compare/illegal) do not occupy the buffer but still need in_ready=1 to be accepted.
- Simultaneous accept and drain: both occur in the same cycle; occupancy is unchanged.
- No data transformation: wb_data equals in_r bit-exactly.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → cpsr=7'b0, wb_valid=0, in_ready=1, sticky_v=0.
- ADD: opcode 00001, in_r=16'h1234, rd=3, set_flags=1, N=0 Z=0 C=1 V=1, wb_ready=1 → next cycle wb_valid=1, wb_rd=3, wb_data=16'h1234, cpsr=7'b0011000, sticky_v=1.
- Compare: opcode 00101, set_flags=0, Z=1, option=3'b010, NAN=1 → no wb_valid, cpsr=7'b0100001. Same compare with option=3'b001 leaves INF/SUB/NAN at prior values.
- Back-pressure: wb_ready=0, issue 3 back-to-back writes with data A,B,C → A in output, B in skid, in_ready=0 so C is held. Raise wb_ready → A, B, C delivered in order, no loss or duplication.
- Illegal opcode 01101 with set_flags=1, V=1 → illegal_op pulses one cycle, cpsr and sticky_v unchanged, no wb_valid.
- Sticky priority: clr_sticky=1 in the same cycle as an accepted flagged op with V=1 → sticky_v=1. Next cycle clr_sticky=1 alone → sticky_v=0.
